// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline memory-access stage. Drives the DCache handshake,
//               stalls EX/MEM while an access is outstanding, aligns load
//               data and registers the MEM/WB result.
//               Optional MEM_ALE_EN: misaligned accesses raise wb_ale.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] PC_RST_VAL = 32'h1c000000
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_we,

    output logic              dc_req,
    output logic              dc_wr,
    output logic [1:0]        dc_size,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [3:0]        dc_wstrb,
    output logic [DATA_W-1:0] dc_wdata,
    input  logic              dc_addr_ok,
    input  logic              dc_data_ok,
    input  logic [DATA_W-1:0] dc_rdata,

    output logic              mem_stall,

    output logic              wb_valid,
    output logic [31:0]       wb_pc,
    output logic [4:0]        wb_rd,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_ale
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_signed;
    logic [1:0]        w_size;
    logic              w_ld;
    logic              w_st;
    logic              w_misaligned;
    logic              w_req;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;

    // Opcode decode; unlisted codes fall through as "no memory op".
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = c_SZ_WORD;
        case (in_op)
            4'b0001: begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = c_SZ_BYTE; end
            4'b0010: begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = c_SZ_HALF; end
            4'b0011: begin w_is_load  = 1'b1;                  w_size = c_SZ_WORD; end
            4'b0100: begin w_is_load  = 1'b1;                  w_size = c_SZ_BYTE; end
            4'b0101: begin w_is_load  = 1'b1;                  w_size = c_SZ_HALF; end
            4'b1001: begin w_is_store = 1'b1;                  w_size = c_SZ_BYTE; end
            4'b1010: begin w_is_store = 1'b1;                  w_size = c_SZ_HALF; end
            4'b1011: begin w_is_store = 1'b1;                  w_size = c_SZ_WORD; end
            default: ;
        endcase
    end

    assign w_ld = in_valid & w_is_load;
    assign w_st = in_valid & w_is_store;

`ifdef MEM_ALE_EN
    assign w_misaligned = (w_ld | w_st) &
                          (((w_size == c_SZ_HALF) & in_addr[0]) |
                           ((w_size == c_SZ_WORD) & (in_addr[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    // Reset low must drop the request immediately to abort any in-flight access.
    assign w_req = rst_n & (w_ld | w_st) & ~w_misaligned & (r_state != c_S_RESP);

    assign dc_req  = w_req;
    assign dc_wr   = w_is_store;
    assign dc_size = w_size;
    assign dc_addr = in_addr;

    always_comb begin
        dc_wstrb = 4'b0000;
        dc_wdata = in_wdata;
        if (w_is_store) begin
            case (w_size)
                c_SZ_BYTE: begin
                    dc_wstrb = 4'b0001 << in_addr[1:0];
                    dc_wdata = {4{in_wdata[7:0]}};
                end
                c_SZ_HALF: begin
                    dc_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
                    dc_wdata = {2{in_wdata[15:0]}};
                end
                default: begin
                    dc_wstrb = 4'b1111;
                    dc_wdata = in_wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (in_addr[1:0])
            2'd0:    w_byte = dc_rdata[7:0];
            2'd1:    w_byte = dc_rdata[15:8];
            2'd2:    w_byte = dc_rdata[23:16];
            default: w_byte = dc_rdata[31:24];
        endcase
        w_half = in_addr[1] ? dc_rdata[31:16] : dc_rdata[15:0];
    end

    always_comb begin
        case (w_size)
            c_SZ_BYTE: w_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load_data = {{16{w_signed & w_half[15]}}, w_half};
            default:   w_load_data = dc_rdata;
        endcase
    end

    // A store completes on address acceptance; a load must also see data_ok.
    always_comb begin
        mem_stall   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE, c_S_REQ: begin
                if (w_req) begin
                    if (dc_addr_ok) begin
                        mem_stall   = ~w_is_store;
                        w_state_nxt = w_is_store ? c_S_IDLE : c_S_RESP;
                    end else begin
                        mem_stall   = 1'b1;
                        w_state_nxt = c_S_REQ;
                    end
                end else begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_RESP: begin
                mem_stall   = ~dc_data_ok;
                w_state_nxt = dc_data_ok ? c_S_IDLE : c_S_RESP;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
        if (!rst_n) begin
            mem_stall   = 1'b0;
            w_state_nxt = c_S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    logic r_ale;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_pc    <= PC_RST_VAL;
            wb_rd    <= 5'd0;
            wb_we    <= 1'b0;
            wb_data  <= '0;
            r_ale    <= 1'b0;
        end else if (mem_stall) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= in_valid;
            wb_pc    <= in_pc;
            wb_rd    <= in_rd;
            wb_we    <= in_we & ~w_st & ~w_misaligned;
            r_ale    <= w_misaligned;
            if (w_misaligned) begin
                wb_data <= in_addr;
            end else if (w_ld) begin
                wb_data <= w_load_data;
            end else begin
                wb_data <= in_alu_res;
            end
        end
    end

`ifdef MEM_ALE_EN
    assign wb_ale = r_ale;
`else
    logic w_ale_unused;
    assign w_ale_unused = r_ale;
    assign wb_ale       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_alu_res;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        dc_req;
    logic        dc_wr;
    logic [1:0]  dc_size;
    logic [31:0] dc_addr;
    logic [3:0]  dc_wstrb;
    logic [31:0] dc_wdata;
    logic        dc_addr_ok;
    logic        dc_data_ok;
    logic [31:0] dc_rdata;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        wb_ale;

    int errors = 0;
    int checks = 0;

    mem_access_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_op      (in_op),
        .in_addr    (in_addr),
        .in_alu_res (in_alu_res),
        .in_wdata   (in_wdata),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .dc_req     (dc_req),
        .dc_wr      (dc_wr),
        .dc_size    (dc_size),
        .dc_addr    (dc_addr),
        .dc_wstrb   (dc_wstrb),
        .dc_wdata   (dc_wdata),
        .dc_addr_ok (dc_addr_ok),
        .dc_data_ok (dc_data_ok),
        .dc_rdata   (dc_rdata),
        .mem_stall  (mem_stall),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .wb_data    (wb_data),
        .wb_ale     (wb_ale)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] pc, input logic [4:0] rd);
        in_valid   = 1'b1;
        in_op      = op;
        in_addr    = addr;
        in_pc      = pc;
        in_rd      = rd;
        in_we      = 1'b1;
        in_alu_res = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_op = 4'h0; in_addr = 32'h0;
        in_alu_res = 32'h0; in_wdata = 32'h0; in_rd = 5'd0; in_we = 1'b0;
        dc_addr_ok = 1'b0; dc_data_ok = 1'b0; dc_rdata = 32'h0;

        // Reset
        tick(); tick();
        chk("rst_wb_pc",    wb_pc, 32'h1c000000);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data",  wb_data, 32'd0);
        chk("rst_wb_rd",    {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_we",    {31'd0, wb_we}, 32'd0);
        chk("rst_wb_ale",   {31'd0, wb_ale}, 32'd0);
        chk("rst_dc_req",   {31'd0, dc_req}, 32'd0);
        chk("rst_stall",    {31'd0, mem_stall}, 32'd0);

        // LD.B at 0x1003, addr_ok cycle 0, data_ok cycle 2
        rst_n = 1'b1;
        set_op(4'b0001, 32'h1003, 32'h100, 5'd3);
        dc_rdata = 32'h80FF0000; dc_addr_ok = 1'b1;
        settle();
        chk("ldb_req",   {31'd0, dc_req}, 32'd1);
        chk("ldb_wr",    {31'd0, dc_wr}, 32'd0);
        chk("ldb_size",  {30'd0, dc_size}, 32'd0);
        chk("ldb_addr",  dc_addr, 32'h1003);
        chk("ldb_stall0", {31'd0, mem_stall}, 32'd1);
        tick();
        dc_addr_ok = 1'b0;
        settle();
        chk("ldb_req_resp", {31'd0, dc_req}, 32'd0);
        chk("ldb_stall1",   {31'd0, mem_stall}, 32'd1);
        chk("ldb_bubble",   {31'd0, wb_valid}, 32'd0);
        tick();
        dc_data_ok = 1'b1;
        settle();
        chk("ldb_stall2", {31'd0, mem_stall}, 32'd0);
        tick();
        dc_data_ok = 1'b0;
        chk("ldb_wb_data",  wb_data, 32'hFFFFFF80);
        chk("ldb_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("ldb_wb_rd",    {27'd0, wb_rd}, 32'd3);
        chk("ldb_wb_we",    {31'd0, wb_we}, 32'd1);
        chk("ldb_wb_pc",    wb_pc, 32'h100);

        // LD.BU same address, best-case latency
        set_op(4'b0100, 32'h1003, 32'h104, 5'd4);
        dc_addr_ok = 1'b1;
        settle();
        chk("ldbu_stall0", {31'd0, mem_stall}, 32'd1);
        tick();
        dc_addr_ok = 1'b0; dc_data_ok = 1'b1;
        settle();
        chk("ldbu_stall1", {31'd0, mem_stall}, 32'd0);
        tick();
        dc_data_ok = 1'b0;
        chk("ldbu_wb_data", wb_data, 32'h00000080);

        // LD.H at 0x1002 (signed upper half)
        set_op(4'b0010, 32'h1002, 32'h108, 5'd6);
        dc_addr_ok = 1'b1;
        tick();
        dc_addr_ok = 1'b0; dc_data_ok = 1'b1;
        tick();
        dc_data_ok = 1'b0;
        chk("ldh_wb_data", wb_data, 32'hFFFF80FF);

        // LD.HU at 0x1000 (lower half, zero-extended)
        set_op(4'b0101, 32'h1000, 32'h10C, 5'd7);
        dc_rdata = 32'h80FF8001; dc_addr_ok = 1'b1;
        tick();
        dc_addr_ok = 1'b0; dc_data_ok = 1'b1;
        tick();
        dc_data_ok = 1'b0;
        chk("ldhu_wb_data", wb_data, 32'h00008001);

        // ST.H at 0x2002, addr_ok delayed 3 cycles
        set_op(4'b1010, 32'h2002, 32'h110, 5'd8);
        in_wdata = 32'h1234ABCD;
        settle();
        chk("sth_req_c0",   {31'd0, dc_req}, 32'd1);
        chk("sth_stall_c0", {31'd0, mem_stall}, 32'd1);
        chk("sth_wstrb",    {28'd0, dc_wstrb}, 32'hC);
        chk("sth_wdata",    dc_wdata, 32'hABCDABCD);
        chk("sth_wr",       {31'd0, dc_wr}, 32'd1);
        chk("sth_size",     {30'd0, dc_size}, 32'd1);
        tick();
        chk("sth_req_c1",   {31'd0, dc_req}, 32'd1);
        chk("sth_stall_c1", {31'd0, mem_stall}, 32'd1);
        chk("sth_bubble",   {31'd0, wb_valid}, 32'd0);
        tick();
        chk("sth_req_c2",   {31'd0, dc_req}, 32'd1);
        tick();
        dc_addr_ok = 1'b1;
        settle();
        chk("sth_req_c3",   {31'd0, dc_req}, 32'd1);
        chk("sth_stall_c3", {31'd0, mem_stall}, 32'd0);
        tick();
        dc_addr_ok = 1'b0;
        chk("sth_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("sth_wb_we",    {31'd0, wb_we}, 32'd0);

        // ST.B at 0x5001, accepted immediately
        set_op(4'b1001, 32'h5001, 32'h114, 5'd9);
        in_wdata = 32'h000000A5; dc_addr_ok = 1'b1;
        settle();
        chk("stb_wstrb", {28'd0, dc_wstrb}, 32'h2);
        chk("stb_wdata", dc_wdata, 32'hA5A5A5A5);
        chk("stb_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        dc_addr_ok = 1'b0;

        // ALU op pass-through
        set_op(4'b0000, 32'h0, 32'h200, 5'd5);
        in_alu_res = 32'hDEADBEEF;
        settle();
        chk("alu_stall", {31'd0, mem_stall}, 32'd0);
        chk("alu_req",   {31'd0, dc_req}, 32'd0);
        tick();
        chk("alu_wb_data",  wb_data, 32'hDEADBEEF);
        chk("alu_wb_rd",    {27'd0, wb_rd}, 32'd5);
        chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu_wb_pc",    wb_pc, 32'h200);

        // Empty slot
        in_valid = 1'b0;
        tick();
        chk("inv_wb_valid", {31'd0, wb_valid}, 32'd0);

        // Reset while in RESP
        set_op(4'b0011, 32'h4000, 32'h300, 5'd10);
        dc_addr_ok = 1'b1;
        tick();
        dc_addr_ok = 1'b0;
        rst_n = 1'b0;
        settle();
        chk("rresp_req",   {31'd0, dc_req}, 32'd0);
        chk("rresp_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("rresp_wb_pc", wb_pc, 32'h1c000000);
        set_op(4'b0000, 32'h0, 32'h304, 5'd11);
        in_alu_res = 32'h0BADF00D;
        settle();
        chk("rresp_idle_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        dc_data_ok = 1'b1;
        in_alu_res = 32'h12345678;
        tick();
        dc_data_ok = 1'b0;
        chk("rresp_ignore_data", wb_data, 32'h12345678);

        // LD.W at 0x3002
        set_op(4'b0011, 32'h3002, 32'h400, 5'd12);
        dc_rdata = 32'hCAFEF00D; dc_addr_ok = 1'b1;
        settle();
`ifdef MEM_ALE_EN
        chk("ale_req",   {31'd0, dc_req}, 32'd0);
        chk("ale_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        dc_addr_ok = 1'b0;
        chk("ale_wb_ale",   {31'd0, wb_ale}, 32'd1);
        chk("ale_wb_data",  wb_data, 32'h3002);
        chk("ale_wb_we",    {31'd0, wb_we}, 32'd0);
        chk("ale_wb_valid", {31'd0, wb_valid}, 32'd1);
`else
        chk("ldw_req",  {31'd0, dc_req}, 32'd1);
        chk("ldw_addr", dc_addr, 32'h3002);
        chk("ldw_size", {30'd0, dc_size}, 32'd2);
        tick();
        dc_addr_ok = 1'b0; dc_data_ok = 1'b1;
        tick();
        dc_data_ok = 1'b0;
        chk("ldw_wb_data", wb_data, 32'hCAFEF00D);
        chk("ldw_wb_ale",  {31'd0, wb_ale}, 32'd0);
`endif

        in_valid = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
